// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master supplies operands and result acceptance; the slave computes.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial d = a - b - bin, LSB first, one bit per clock through a single
// borrow flip-flop; difference, unsigned borrow-out and signed overflow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic             x;
  logic             br_next;
  logic [WIDTH:0]   d_cat;
  logic [WIDTH-1:0] d_next;

  // One-bit subtract slice; the new bit enters the result at the MSB end.
  always_comb begin
    x       = a_sr[0] ^ b_sr[0] ^ br;
    br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    d_cat   = {x, d_sr};
    d_next  = d_cat[WIDTH:1];
  end

  assign bus.in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_sr          <= '0;
      b_sr          <= '0;
      d_sr          <= '0;
      br            <= 1'b0;
      cnt           <= '0;
      a_msb         <= 1'b0;
      b_msb         <= 1'b0;
      bus.d         <= '0;
      bus.bout      <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            br    <= bus.bin;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_next;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            // On the last slice x is the result MSB, so overflow is decided here.
            bus.d         <= d_next;
            bus.bout      <= br_next;
            bus.ovf       <= (a_msb != b_msb) && (x != a_msb);
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed and random traffic,
// plus a WIDTH=1 instance under random traffic.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  int   mode;           // out_ready policy: 0 always, 1 random, 2 never
  int   edges = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  serial_subtractor_if #(.WIDTH(8)) b8 ();
  serial_subtractor_if #(.WIDTH(1)) b1 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  serial_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  typedef struct {
    logic [31:0] d;
    logic        bout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  logic ov8_q = 1'b0;
  logic ov1_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic bin, input int acc);
    exp_t   e;
    longint ua, ub, r, sa, sb, sr, span;
    span = longint'(1) << w;
    ua = longint'(a); ub = longint'(b);
    r  = ua - ub - longint'(bin);
    sa = a[w-1] ? ua - span : ua;
    sb = b[w-1] ? ub - span : ub;
    sr = sa - sb - longint'(bin);
    e.d    = 32'(r & (span - 1));
    e.bout = (r < 0);
    e.ovf  = (sr < -(span / 2)) || (sr > (span / 2) - 1);
    e.acc  = acc;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    b8.out_ready = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    b1.out_ready = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  // Handshakes observed at the negedge commit on the following posedge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q8.delete();
    end else begin
      if (b8.out_valid && !ov8_q) begin
        if (q8.size() == 0) check("q8_nonempty", q8.size(), 1);
        else check("lat8", edges - q8[0].acc, 8);
      end
      if (b8.in_valid && b8.in_ready) q8.push_back(model(8, b8.a, b8.b, b8.bin, edges + 1));
      if (b8.out_valid && b8.out_ready && q8.size() > 0) begin
        e = q8.pop_front();
        check("d8", b8.d, e.d);
        check("bout8", b8.bout, e.bout);
        check("ovf8", b8.ovf, e.ovf);
      end
    end
    ov8_q <= rst_n && b8.out_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q1.delete();
    end else begin
      if (b1.out_valid && !ov1_q) begin
        if (q1.size() == 0) check("q1_nonempty", q1.size(), 1);
        else check("lat1", edges - q1[0].acc, 1);
      end
      if (b1.in_valid && b1.in_ready) q1.push_back(model(1, b1.a, b1.b, b1.bin, edges + 1));
      if (b1.out_valid && b1.out_ready && q1.size() > 0) begin
        e = q1.pop_front();
        check("d1", b1.d, e.d);
        check("bout1", b1.bout, e.bout);
        check("ovf1", b1.ovf, e.ovf);
      end
    end
    ov1_q <= rst_n && b1.out_valid;
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    b8.a = a; b8.b = b; b8.bin = bin; b8.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b8.in_ready) begin
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        return;
      end
    end
    check("accept8_timeout", b8.in_ready, 1);
    b8.in_valid = 1'b0;
  endtask

  task automatic issue1(input logic a, input logic b, input logic bin);
    b1.a = a; b1.b = b; b1.bin = bin; b1.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b1.in_ready) begin
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        return;
      end
    end
    check("accept1_timeout", b1.in_ready, 1);
    b1.in_valid = 1'b0;
  endtask

  task automatic wait_out8();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b8.out_valid) return;
    end
    check("out8_timeout", b8.out_valid, 1);
  endtask

  task automatic run_dir8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] ed, input logic eb, input logic eo);
    issue8(a, b, bin);
    check("in_ready_busy", b8.in_ready, 0);
    wait_out8();
    check("dir_d", b8.d, ed);
    check("dir_bout", b8.bout, eb);
    check("dir_ovf", b8.ovf, eo);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; mode = 0;
    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.bin = 1'b0;
    b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", b8.in_ready, 1);
    check("rst_out_valid", b8.out_valid, 0);
    check("rst_d", b8.d, 0);
    check("rst_bout", b8.bout, 0);
    check("rst_ovf", b8.ovf, 0);
    rst_n = 1'b1;

    run_dir8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    run_dir8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_dir8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_dir8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_dir8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    run_dir8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_dir8(8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1);

    // Backpressure: result must hold and no new operands may be taken.
    mode = 2;
    run_dir8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      b8.in_valid = ~b8.in_valid;
      b8.a = 8'($urandom); b8.b = 8'($urandom); b8.bin = 1'($urandom);
      @(negedge clk);
      check("bp_valid", b8.out_valid, 1);
      check("bp_in_ready", b8.in_ready, 0);
      check("bp_d", b8.d, 8'h22);
      check("bp_bout", b8.bout, 0);
    end
    b8.in_valid = 1'b0;
    mode = 0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n = i;
      if (!b8.out_valid) break;
    end
    check("bp_release_cycles", n, 2);
    check("bp_release_in_ready", b8.in_ready, 1);

    // Reset in the middle of a computation.
    issue8(8'h5A, 8'h3C, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", b8.out_valid, 0);
    check("mid_rst_d", b8.d, 0);
    check("mid_rst_bout", b8.bout, 0);
    check("mid_rst_ovf", b8.ovf, 0);
    check("mid_rst_in_ready", b8.in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    run_dir8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    mode = 1;
    for (int i = 0; i < 1000; i++) issue8(8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q8.size() == 0 && !b8.out_valid) break;
    end
    check("drain8", q8.size(), 0);

    for (int i = 0; i < 200; i++) issue1(1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && !b1.out_valid) break;
    end
    check("drain1", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
